// File: rtl/montacarga_pkg.sv
// Shared types and helpers for the freight-elevator (montacarga) blocks.
// Floor numbering: bit N-1 of a floor vector is floor 1, bit 0 is the top floor.
package montacarga_pkg;

    localparam int N_PISOS_DEF = 5;

    typedef enum logic [2:0] {
        REPOSO,
        SUBIENDO,
        BAJANDO,
        PARADA,
        EMERG
    } estado_t;

    localparam logic [1:0] MOT_STOP = 2'b00;
    localparam logic [1:0] MOT_UP   = 2'b10;
    localparam logic [1:0] MOT_DOWN = 2'b01;

    localparam logic [6:0] SEG_E = 7'b1001111;

    function automatic logic [2:0] bit_a_piso(input int n, input int b);
        return 3'(n - b);
    endfunction

    function automatic logic [6:0] piso_a_oh(input int n, input logic [2:0] p);
        logic [6:0] v;
        v = '0;
        for (int b = 0; b < 7; b++) begin
            if (b < n && bit_a_piso(n, b) == p) begin
                v[b] = 1'b1;
            end
        end
        return v;
    endfunction

    function automatic logic [6:0] seg7(input logic [2:0] p);
        logic [6:0] s;
        case (p)
            3'd1:    s = 7'b0110000;
            3'd2:    s = 7'b1101101;
            3'd3:    s = 7'b1111001;
            3'd4:    s = 7'b0110011;
            3'd5:    s = 7'b1011011;
            3'd6:    s = 7'b1011111;
            3'd7:    s = 7'b1110000;
            default: s = 7'b0000000;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/contador_espera.sv
// Dwell counter: clears to zero, counts while enabled, flags the last cycle.
// The count wraps to zero on the terminal cycle so a new stop always starts fresh.
module contador_espera
    import montacarga_pkg::*;
#(
    parameter int DWELL_CYCLES = 8
) (
    input  logic clk,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam int W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam logic [W-1:0] ULTIMO = W'(DWELL_CYCLES - 1);

    logic [W-1:0] cnt_q, cnt_d;

    assign tc_o = (cnt_q == ULTIMO);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i || (en_i && tc_o)) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/planificador_llamadas.sv
// SCAN call scheduler for the freight elevator: latches calls, drives the motor.
// Optional PLANIFICADOR_DISPLAY_EN adds a registered 7-segment floor display.
module planificador_llamadas
    import montacarga_pkg::*;
#(
    parameter int N_PISOS      = N_PISOS_DEF,
    parameter int DWELL_CYCLES = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_PISOS-1:0] selector,
    input  logic [N_PISOS-1:0] fc,
    input  logic               emergencia,
    input  logic               puerta,
    output logic [1:0]         salida,
    output logic [N_PISOS-1:0] pendientes,
    output logic [2:0]         piso_actual,
    output logic               led_emergencia,
    output logic               led_puerta
`ifdef PLANIFICADOR_DISPLAY_EN
    ,
    output logic [6:0]         display
`endif
);

    estado_t            state_q, state_d;
    logic               dir_q, dir_d;
    logic [1:0]         salida_q, salida_d;
    logic [N_PISOS-1:0] pend_q, pend_d;
    logic [2:0]         piso_q, piso_d;
    logic               led_pu_q;

    logic [3:0]         fc_n;
    logic [2:0]         fc_piso;
    logic               fc_ok;
    logic               arriba, abajo, aqui;
    logic [6:0]         oh7;
    logic [N_PISOS-1:0] aqui_m;
    logic               seguir, volver, nuevo_dir;
    logic               tc, fin_espera;

    always_comb begin
        fc_n    = '0;
        fc_piso = '0;
        arriba  = 1'b0;
        abajo   = 1'b0;
        for (int b = 0; b < N_PISOS; b++) begin
            if (fc[b]) begin
                fc_n    = fc_n + 4'd1;
                fc_piso = bit_a_piso(N_PISOS, b);
            end
            if (pend_q[b] && bit_a_piso(N_PISOS, b) > piso_q) begin
                arriba = 1'b1;
            end
            if (pend_q[b] && bit_a_piso(N_PISOS, b) < piso_q) begin
                abajo = 1'b1;
            end
        end
        fc_ok  = (fc_n == 4'd1);
        oh7    = piso_a_oh(N_PISOS, piso_q);
        aqui_m = oh7[N_PISOS-1:0];
        aqui   = |(pend_q & aqui_m);
    end

    contador_espera #(
        .DWELL_CYCLES(DWELL_CYCLES)
    ) u_espera (
        .clk   (clk),
        .rst_ni(reset),
        .clr_i (state_q != PARADA || puerta),
        .en_i  (state_q == PARADA),
        .tc_o  (tc)
    );

    assign fin_espera = tc && !puerta;

    always_comb begin
        state_d   = state_q;
        dir_d     = dir_q;
        salida_d  = salida_q;
        pend_d    = pend_q | selector;
        piso_d    = fc_ok ? fc_piso : piso_q;
        seguir    = dir_q ? arriba : abajo;
        volver    = dir_q ? abajo : arriba;
        nuevo_dir = seguir ? dir_q : ~dir_q;
        unique case (state_q)
            REPOSO: begin
                salida_d = MOT_STOP;
                if (!puerta) begin
                    if (aqui) begin
                        pend_d  = pend_d & ~aqui_m;
                        state_d = PARADA;
                    end else if (arriba && (dir_q || !abajo)) begin
                        state_d  = SUBIENDO;
                        dir_d    = 1'b1;
                        salida_d = MOT_UP;
                    end else if (abajo) begin
                        state_d  = BAJANDO;
                        dir_d    = 1'b0;
                        salida_d = MOT_DOWN;
                    end
                end
            end
            SUBIENDO, BAJANDO: begin
                // an open door parks the motor but keeps the trip alive
                salida_d = puerta ? MOT_STOP
                         : (state_q == SUBIENDO ? MOT_UP : MOT_DOWN);
                if (fc_ok && (|(pend_q & fc)
                    || (state_q == SUBIENDO && fc_piso == 3'(N_PISOS))
                    || (state_q == BAJANDO && fc_piso == 3'd1))) begin
                    pend_d   = pend_d & ~fc;
                    state_d  = PARADA;
                    salida_d = MOT_STOP;
                end
            end
            PARADA: begin
                salida_d = MOT_STOP;
                if (fin_espera) begin
                    if (seguir || volver) begin
                        dir_d    = nuevo_dir;
                        state_d  = nuevo_dir ? SUBIENDO : BAJANDO;
                        salida_d = nuevo_dir ? MOT_UP : MOT_DOWN;
                    end else begin
                        state_d = REPOSO;
                    end
                end
            end
            EMERG: begin
                pend_d   = '0;
                salida_d = puerta ? MOT_STOP : MOT_DOWN;
                if (fc_ok && fc_piso == 3'd1) begin
                    state_d  = REPOSO;
                    salida_d = MOT_STOP;
                end
            end
            default: begin
                state_d  = REPOSO;
                salida_d = MOT_STOP;
            end
        endcase
        if (emergencia && state_q != EMERG) begin
            state_d  = EMERG;
            pend_d   = '0;
            dir_d    = 1'b0;
            salida_d = puerta ? MOT_STOP : MOT_DOWN;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= REPOSO;
            dir_q    <= 1'b1;
            salida_q <= MOT_STOP;
            pend_q   <= '0;
            piso_q   <= 3'd1;
            led_pu_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            dir_q    <= dir_d;
            salida_q <= salida_d;
            pend_q   <= pend_d;
            piso_q   <= piso_d;
            led_pu_q <= puerta;
        end
    end

    assign salida         = salida_q;
    assign pendientes     = pend_q;
    assign piso_actual    = piso_q;
    assign led_emergencia = (state_q == EMERG);
    assign led_puerta     = led_pu_q;

`ifdef PLANIFICADOR_DISPLAY_EN
    logic [6:0] display_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            display_q <= seg7(3'd1);
        end else begin
            display_q <= (state_d == EMERG) ? SEG_E : seg7(piso_d);
        end
    end

    assign display = display_q;
`endif

endmodule

// File: tb/tb_planificador_llamadas.sv
// Bench for planificador_llamadas: directed scenarios, then random traffic
// against a floor-level behavioural model and a simple car/shaft plant.
module tb_planificador_llamadas;

    localparam int N = 5;
    localparam int D = 8;

    localparam int M_IDLE = 0;
    localparam int M_UP   = 1;
    localparam int M_DN   = 2;
    localparam int M_STOP = 3;
    localparam int M_EMG  = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [N-1:0] selector = '0;
    logic [N-1:0] fc = '0;
    logic         emergencia = 1'b0;
    logic         puerta = 1'b0;
    logic [1:0]   salida;
    logic [N-1:0] pendientes;
    logic [2:0]   piso_actual;
    logic         led_emergencia;
    logic         led_puerta;
`ifdef PLANIFICADOR_DISPLAY_EN
    logic [6:0]   display;
`endif

    int checks = 0;
    int failures = 0;

    int       m_mode, m_piso, m_wait, m_sal;
    bit       m_up, m_ledp;
    bit [7:1] mp;

    int h = 0;
    bit plant_en = 1'b0;
    bit glitch = 1'b0;

    planificador_llamadas #(
        .N_PISOS(N),
        .DWELL_CYCLES(D)
    ) dut (
        .clk(clk),
        .reset(reset),
        .selector(selector),
        .fc(fc),
        .emergencia(emergencia),
        .puerta(puerta),
        .salida(salida),
        .pendientes(pendientes),
        .piso_actual(piso_actual),
        .led_emergencia(led_emergencia),
        .led_puerta(led_puerta)
`ifdef PLANIFICADOR_DISPLAY_EN
        ,
        .display(display)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [N-1:0] oh(input int f);
        logic [N-1:0] v;
        v = '0;
        v[N-f] = 1'b1;
        return v;
    endfunction

    function automatic logic [N-1:0] pack_mp();
        logic [N-1:0] v;
        v = '0;
        for (int f = 1; f <= N; f++) v[N-f] = mp[f];
        return v;
    endfunction

    function automatic logic [6:0] seg_ref(input int f);
        case (f)
            1: return 7'b0110000;
            2: return 7'b1101101;
            3: return 7'b1111001;
            4: return 7'b0110011;
            5: return 7'b1011011;
            default: return 7'b0000000;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        int fl;
        bit valid, up_c, dn_c, here_c, cont, back, nd;
        bit [7:1] np;
        int n_mode, n_piso, n_wait, n_sal;
        bit n_up;
        if (reset == 1'b0) begin
            m_mode = M_IDLE; m_sal = 0; mp = '0; m_piso = 1;
            m_up = 1'b1; m_wait = 0; m_ledp = 1'b0;
            return;
        end
        valid = ($countones(fc) == 1);
        fl = 0;
        for (int b = 0; b < N; b++) if (fc[b]) fl = N - b;
        up_c = 0; dn_c = 0; here_c = 0;
        for (int f = 1; f <= N; f++) begin
            if (mp[f]) begin
                if (f > m_piso) up_c = 1;
                else if (f < m_piso) dn_c = 1;
                else here_c = 1;
            end
        end
        np = mp;
        for (int f = 1; f <= N; f++) if (selector[N-f]) np[f] = 1'b1;
        n_mode = m_mode; n_up = m_up; n_sal = m_sal; n_wait = 0;
        n_piso = valid ? fl : m_piso;
        case (m_mode)
            M_IDLE: begin
                n_sal = 0;
                if (!puerta) begin
                    if (here_c) begin
                        np[m_piso] = 1'b0; n_mode = M_STOP;
                    end else if (up_c && (m_up || !dn_c)) begin
                        n_mode = M_UP; n_up = 1; n_sal = 2;
                    end else if (dn_c) begin
                        n_mode = M_DN; n_up = 0; n_sal = 1;
                    end
                end
            end
            M_UP, M_DN: begin
                n_sal = puerta ? 0 : (m_mode == M_UP ? 2 : 1);
                if (valid && (mp[fl] || (m_mode == M_UP && fl == N)
                              || (m_mode == M_DN && fl == 1))) begin
                    np[fl] = 1'b0; n_mode = M_STOP; n_sal = 0;
                end
            end
            M_STOP: begin
                n_sal = 0;
                if (puerta) n_wait = 0;
                else if (m_wait == D - 1) begin
                    cont = m_up ? up_c : dn_c;
                    back = m_up ? dn_c : up_c;
                    if (cont || back) begin
                        nd = cont ? m_up : !m_up;
                        n_up = nd;
                        n_mode = nd ? M_UP : M_DN;
                        n_sal = nd ? 2 : 1;
                    end else n_mode = M_IDLE;
                end else n_wait = m_wait + 1;
            end
            default: begin
                np = '0;
                n_sal = puerta ? 0 : 1;
                if (valid && fl == 1) begin
                    n_mode = M_IDLE; n_sal = 0;
                end
            end
        endcase
        if (emergencia && m_mode != M_EMG) begin
            n_mode = M_EMG; np = '0; n_up = 0; n_sal = puerta ? 0 : 1;
        end
        m_mode = n_mode; m_up = n_up; m_sal = n_sal; m_wait = n_wait;
        m_piso = n_piso; mp = np; m_ledp = puerta;
    endtask

    task automatic tick();
        if (plant_en) begin
            fc = (h % 4 == 0) ? oh(h / 4 + 1) : '0;
            if (glitch && fc != '0) fc = fc | oh($urandom_range(1, N));
        end
        model_step();
        @(posedge clk);
        #1;
        chk("salida", 32'(salida), 32'(m_sal));
        chk("pendientes", 32'(pendientes), 32'(pack_mp()));
        chk("piso", 32'(piso_actual), 32'(m_piso));
        chk("led_em", 32'(led_emergencia), 32'(m_mode == M_EMG));
        chk("led_pu", 32'(led_puerta), 32'(m_ledp));
`ifdef PLANIFICADOR_DISPLAY_EN
        chk("display", 32'(display),
            32'(m_mode == M_EMG ? 7'b1001111 : seg_ref(m_piso)));
`endif
        if (plant_en) begin
            if (salida == 2'b10 && h < 4 * (N - 1)) h++;
            else if (salida == 2'b01 && h > 0) h--;
        end
        if (!reset) h = 0;
    endtask

    task automatic wait_floor(input int f, input bit stopped, input string tag);
        int n;
        bit ok;
        n = 0;
        ok = 1'b0;
        while (n < 300 && !ok) begin
            tick();
            n++;
            ok = (int'(piso_actual) == f) && (!stopped || salida == 2'b00);
        end
        checks++;
        assert (ok)
        else begin
            failures++;
            $error("FAIL %s: piso=%0d salida=%b required floor %0d", tag,
                   piso_actual, salida, f);
        end
    endtask

    initial begin
        // reset state
        fc = oh(1);
        reset = 1'b0;
        tick();
        tick();
        chk("rst_salida", 32'(salida), 32'(2'b00));
        chk("rst_pend", 32'(pendientes), 32'(0));
        chk("rst_piso", 32'(piso_actual), 32'(1));
        chk("rst_led", 32'({led_emergencia, led_puerta}), 32'(0));
`ifdef PLANIFICADOR_DISPLAY_EN
        chk("rst_disp", 32'(display), 32'(7'b0110000));
`endif
        reset = 1'b1;

        // single call to floor 2
        selector = oh(2);
        tick();
        chk("t1_pend", 32'(pendientes), 32'(5'b01000));
        chk("t1_idle", 32'(salida), 32'(2'b00));
        selector = '0;
        fc = '0;
        tick();
        chk("t1_up", 32'(salida), 32'(2'b10));
        tick();
        tick();
        fc = oh(2);
        tick();
        chk("t1_stop", 32'(salida), 32'(2'b00));
        chk("t1_piso", 32'(piso_actual), 32'(2));
        chk("t1_clr", 32'(pendientes), 32'(0));
        repeat (D) tick();

        // SCAN: 3 and 5 upward, then 1
        h = 4;
        plant_en = 1'b1;
        selector = oh(3) | oh(5);
        tick();
        selector = oh(1);
        tick();
        selector = '0;
        wait_floor(3, 1'b1, "t2_stop3");
`ifdef PLANIFICADOR_DISPLAY_EN
        chk("t6_disp3", 32'(display), 32'(7'b1111001));
`endif
        wait_floor(5, 1'b1, "t2_stop5");
        wait_floor(1, 1'b1, "t2_stop1");
        repeat (D + 2) tick();

        // emergency while travelling up
        selector = oh(5);
        tick();
        selector = '0;
        wait_floor(3, 1'b0, "t3_pass3");
        emergencia = 1'b1;
        tick();
        emergencia = 1'b0;
        chk("t3_pend", 32'(pendientes), 32'(0));
        chk("t3_led", 32'(led_emergencia), 32'(1));
        chk("t3_down", 32'(salida), 32'(2'b01));
`ifdef PLANIFICADOR_DISPLAY_EN
        chk("t6_dispE", 32'(display), 32'(7'b1001111));
`endif
        emergencia = 1'b1;
        selector = oh(4);
        tick();
        emergencia = 1'b0;
        selector = '0;
        wait_floor(1, 1'b1, "t3_home");
        chk("t3_ledoff", 32'(led_emergencia), 32'(0));

        // door inhibit at floor 1
        puerta = 1'b1;
        selector = oh(3);
        tick();
        selector = '0;
        chk("t4_pend", 32'(pendientes), 32'(5'b00100));
        tick();
        tick();
        chk("t4_hold", 32'(salida), 32'(2'b00));
        puerta = 1'b0;
        tick();
        chk("t4_go", 32'(salida), 32'(2'b10));
        wait_floor(3, 1'b1, "t4_stop3");
        repeat (D + 1) tick();

        // invalid limit switch, then reset mid-travel
        selector = oh(5);
        tick();
        selector = '0;
        tick();
        plant_en = 1'b0;
        fc = 5'b01100;
        tick();
        chk("t5_piso", 32'(piso_actual), 32'(3));
        chk("t5_move", 32'(salida), 32'(2'b10));
        reset = 1'b0;
        tick();
        chk("t5_rsal", 32'(salida), 32'(2'b00));
        chk("t5_rpend", 32'(pendientes), 32'(0));
        chk("t5_rpiso", 32'(piso_actual), 32'(1));
        reset = 1'b1;
        h = 0;
        plant_en = 1'b1;

        // random traffic
        for (int i = 0; i < 4000; i++) begin
            selector = ($urandom_range(0, 7) == 0)
                     ? N'($urandom_range(1, (1 << N) - 1)) : '0;
            if ($urandom_range(0, 39) == 0) puerta = ~puerta;
            emergencia = ($urandom_range(0, 249) == 0);
            reset = ($urandom_range(0, 599) != 0);
            glitch = ($urandom_range(0, 24) == 0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
